// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle for uart_tx_arbiter: two requester handshakes, the transmit-engine
// load/ready pair, and the status outputs.
interface uart_tx_arbiter_if #(
  parameter int CNT_W = 8
);
  logic             req0_valid;
  logic [7:0]       req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [7:0]       req1_data;
  logic             req1_ready;
  logic             txrdy;
  logic             load;
  logic [7:0]       out_port;
  logic             busy;
  logic             grant_id;
  logic [CNT_W-1:0] sent0;
  logic [CNT_W-1:0] sent1;
  logic             to_err;
  logic             clr_err;

  // Environment side: requesters, transmit engine and status reader.
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, txrdy, clr_err,
    input  req0_ready, req1_ready, load, out_port, busy, grant_id, sent0, sent1, to_err
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, txrdy, clr_err,
    output req0_ready, req1_ready, load, out_port, busy, grant_id, sent0, sent1, to_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit engine between two byte requesters,
// with per-requester sent counters and a sticky load-acknowledge timeout flag.
module uart_tx_arbiter #(
  parameter int CNT_W       = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_LOW,
    S_WAIT_HIGH
  } state_t;

  // Last WAIT_LOW count value at which TXRDY may still be high before giving up.
  localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);

  state_t           state, state_next;
  logic             rr;
  logic             grant;
  logic [7:0]       hold;
  logic [7:0]       wait_cnt;
  logic [CNT_W-1:0] sent0, sent1;
  logic             to_err;

  logic             accept;
  logic             winner;
  logic             timeout;
  logic             done;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    winner     = 1'b0;
    timeout    = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.txrdy && (bus.req0_valid || bus.req1_valid)) begin
          accept     = 1'b1;
          winner     = (bus.req0_valid && bus.req1_valid) ? ~rr : bus.req1_valid;
          state_next = S_LOAD;
        end
      end
      S_LOAD: state_next = S_WAIT_LOW;
      S_WAIT_LOW: begin
        // A falling TXRDY on the last allowed cycle still counts as an acknowledge.
        if (!bus.txrdy) begin
          state_next = S_WAIT_HIGH;
        end else if (wait_cnt == ACK_LAST) begin
          timeout    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_WAIT_HIGH: begin
        if (bus.txrdy) begin
          done       = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the hold byte is a plain register, not a memory array, so it is reset with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr       <= 1'b0;
      grant    <= 1'b0;
      hold     <= 8'h00;
      wait_cnt <= 8'h00;
      sent0    <= '0;
      sent1    <= '0;
      to_err   <= 1'b0;
    end else begin
      if (accept) begin
        hold  <= winner ? bus.req1_data : bus.req0_data;
        grant <= winner;
        rr    <= winner;
      end

      wait_cnt <= (state == S_WAIT_LOW) ? wait_cnt + 8'd1 : 8'h00;

      if (done) begin
        if (grant) sent1 <= sent1 + 1'b1;
        else       sent0 <= sent0 + 1'b1;
      end

      // A timeout in the same cycle as a clear request leaves the flag set.
      if (timeout)          to_err <= 1'b1;
      else if (bus.clr_err) to_err <= 1'b0;
    end
  end

  assign bus.req0_ready = accept && !winner;
  assign bus.req1_ready = accept && winner;
  assign bus.load       = (state == S_LOAD);
  assign bus.out_port   = (state == S_LOAD) ? hold : 8'h00;
  assign bus.busy       = (state != S_IDLE);
  assign bus.grant_id   = grant;
  assign bus.sent0      = sent0;
  assign bus.sent1      = sent1;
  assign bus.to_err     = to_err;

endmodule
